// File: rtl/sram22_512x32_arb.sv
// Two-requester front-end for the 512x32 SRAM22 macro: zero-fills the array after reset,
// then shares the single macro port between requesters A and B with round-robin arbitration.
module sram22_512x32_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic                  a_req_we,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic [DATA_WIDTH-1:0] a_req_din,
    output logic                  a_rsp_valid,
    input  logic                  a_rsp_ready,
    output logic [DATA_WIDTH-1:0] a_rsp_data,

    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic                  b_req_we,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    input  logic [DATA_WIDTH-1:0] b_req_din,
    output logic                  b_rsp_valid,
    input  logic                  b_rsp_ready,
    output logic [DATA_WIDTH-1:0] b_rsp_data,

    output logic                  mem_we,
    output logic                  mem_wmask,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,

    output logic                  init_done
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    ptr_q, ptr_d;
    logic                    init_done_q, init_done_d;
    logic                    a_rd_q, a_rd_d;
    logic                    b_rd_q, b_rd_d;
    logic                    a_rsp_valid_q, a_rsp_valid_d;
    logic                    b_rsp_valid_q, b_rsp_valid_d;
    logic [DATA_WIDTH-1:0]   a_rsp_data_q, a_rsp_data_d;
    logic [DATA_WIDTH-1:0]   b_rsp_data_q, b_rsp_data_d;

    logic run;
    logic a_elig, b_elig;
    logic grant_a, grant_b;

    // A read waits out its own previous read and needs a free (or draining) response slot.
    always_comb begin
        run     = (state_q == ST_RUN);
        a_elig  = run && a_req_valid &&
                  (a_req_we || (!a_rd_q && (!a_rsp_valid_q || a_rsp_ready)));
        b_elig  = run && b_req_valid &&
                  (b_req_we || (!b_rd_q && (!b_rsp_valid_q || b_rsp_ready)));
        grant_a = a_elig && (!b_elig || !ptr_q);
        grant_b = b_elig && !grant_a;
    end

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (!run) begin
            mem_we   = 1'b1;
            mem_addr = cnt_q;
        end else if (grant_a) begin
            mem_we   = a_req_we;
            mem_addr = a_req_addr;
            mem_din  = a_req_din;
        end else if (grant_b) begin
            mem_we   = b_req_we;
            mem_addr = b_req_addr;
            mem_din  = b_req_din;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        ptr_d       = ptr_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
                state_d     = ST_RUN;
                init_done_d = 1'b1;
            end
        end
        if (grant_a) begin
            ptr_d = 1'b1;
        end else if (grant_b) begin
            ptr_d = 1'b0;
        end
    end

    // The macro presents read data one edge after sampling; a capture beats a same-edge consume.
    always_comb begin
        a_rd_d        = grant_a && !a_req_we;
        b_rd_d        = grant_b && !b_req_we;
        a_rsp_valid_d = a_rsp_valid_q;
        a_rsp_data_d  = a_rsp_data_q;
        b_rsp_valid_d = b_rsp_valid_q;
        b_rsp_data_d  = b_rsp_data_q;
        if (a_rd_q) begin
            a_rsp_valid_d = 1'b1;
            a_rsp_data_d  = mem_dout;
        end else if (a_rsp_ready) begin
            a_rsp_valid_d = 1'b0;
        end
        if (b_rd_q) begin
            b_rsp_valid_d = 1'b1;
            b_rsp_data_d  = mem_dout;
        end else if (b_rsp_ready) begin
            b_rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_INIT;
            cnt_q         <= '0;
            ptr_q         <= 1'b0;
            init_done_q   <= 1'b0;
            a_rd_q        <= 1'b0;
            b_rd_q        <= 1'b0;
            a_rsp_valid_q <= 1'b0;
            b_rsp_valid_q <= 1'b0;
            a_rsp_data_q  <= '0;
            b_rsp_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ptr_q         <= ptr_d;
            init_done_q   <= init_done_d;
            a_rd_q        <= a_rd_d;
            b_rd_q        <= b_rd_d;
            a_rsp_valid_q <= a_rsp_valid_d;
            b_rsp_valid_q <= b_rsp_valid_d;
            a_rsp_data_q  <= a_rsp_data_d;
            b_rsp_data_q  <= b_rsp_data_d;
        end
    end

    assign a_req_ready = grant_a;
    assign b_req_ready = grant_b;
    assign a_rsp_valid = a_rsp_valid_q;
    assign b_rsp_valid = b_rsp_valid_q;
    assign a_rsp_data  = a_rsp_data_q;
    assign b_rsp_data  = b_rsp_data_q;
    assign mem_wmask   = 1'b1;
    assign init_done   = init_done_q;

endmodule

// File: tb/tb_sram22_512x32_arb.sv
// Directed bench for sram22_512x32_arb with a behavioural macro model that returns
// non-zero filler for never-written words, so the zero-fill is actually observable.
module tb_sram22_512x32_arb;

    logic        clk;
    logic        rst_n;
    logic        a_req_valid, a_req_we, a_rsp_ready;
    logic [8:0]  a_req_addr;
    logic [31:0] a_req_din;
    logic        b_req_valid, b_req_we, b_rsp_ready;
    logic [8:0]  b_req_addr;
    logic [31:0] b_req_din;
    logic        a_req_ready, a_rsp_valid, b_req_ready, b_rsp_valid;
    logic [31:0] a_rsp_data, b_rsp_data;
    logic        mem_we, mem_wmask, init_done;
    logic [8:0]  mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    int tests = 0;
    int fails = 0;

    bit [31:0]  ram [512];
    bit [511:0] written;

    sram22_512x32_arb dut (
        .clk(clk), .rst_n(rst_n),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
        .a_req_addr(a_req_addr), .a_req_din(a_req_din), .a_rsp_valid(a_rsp_valid),
        .a_rsp_ready(a_rsp_ready), .a_rsp_data(a_rsp_data),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
        .b_req_addr(b_req_addr), .b_req_din(b_req_din), .b_rsp_valid(b_rsp_valid),
        .b_rsp_ready(b_rsp_ready), .b_rsp_data(b_rsp_data),
        .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .init_done(init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port macro model: synchronous write, registered read; unwritten words hold filler.
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr]     <= mem_din;
            written[mem_addr] <= 1'b1;
        end
        mem_dout <= written[mem_addr] ? ram[mem_addr] : (32'hA5A5_0000 | {23'd0, mem_addr});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        tests++; if (a_req_ready !== 1'b0 || b_req_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_req_ready got a=%0b b=%0b exp 0", a_req_ready, b_req_ready); end
        tests++; if (a_rsp_valid !== 1'b0 || b_rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_rsp_valid got a=%0b b=%0b exp 0", a_rsp_valid, b_rsp_valid); end
        tests++; if (a_rsp_data !== 32'd0 || b_rsp_data !== 32'd0) begin fails++; $display("[TB] FAIL reset_rsp_data got a=%h b=%h exp 0", a_rsp_data, b_rsp_data); end
        tests++; if (init_done !== 1'b0) begin fails++; $display("[TB] FAIL reset_init_done got %0b exp 0", init_done); end
        tests++; if (mem_we !== 1'b1 || mem_addr !== 9'd0 || mem_din !== 32'd0 || mem_wmask !== 1'b1) begin fails++; $display("[TB] FAIL reset_mem got we=%0b addr=%h din=%h wmask=%0b exp 1/0/0/1", mem_we, mem_addr, mem_din, mem_wmask); end
    endtask

    task automatic test_init();
        int bad;
        logic [8:0] zaddr [3];
        zaddr[0] = 9'd0; zaddr[1] = 9'd255; zaddr[2] = 9'd511;
        bad = 0;
        tick();
        rst_n = 1'b1;
        a_req_valid = 1'b1; b_req_valid = 1'b1; a_req_we = 1'b0; b_req_we = 1'b0;
        a_req_addr = 9'd0; b_req_addr = 9'd0; a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
        for (int i = 0; i < 512; i++) begin
            #1;
            if (a_req_ready !== 1'b0 || b_req_ready !== 1'b0 || mem_we !== 1'b1 ||
                mem_addr !== 9'(i) || mem_din !== 32'd0 || init_done !== 1'b0) begin
                if (bad == 0) $display("[TB] FAIL init_cycle_%0d got rdy=%0b%0b we=%0b addr=%0d done=%0b exp 00/1/%0d/0", i, a_req_ready, b_req_ready, mem_we, mem_addr, init_done, i);
                bad++;
            end
            tick();
        end
        tests++; if (bad !== 0) begin fails++; $display("[TB] FAIL init_sequence got %0d bad cycles exp 0", bad); end
        #1;
        tests++; if (init_done !== 1'b1) begin fails++; $display("[TB] FAIL init_done_rise got %0b exp 1", init_done); end
        tests++; if (a_req_ready !== 1'b1 || b_req_ready !== 1'b0) begin fails++; $display("[TB] FAIL first_run_grant got a=%0b b=%0b exp 1/0", a_req_ready, b_req_ready); end
        b_req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a_req_addr = zaddr[k];
            a_req_valid = 1'b1;
            tick();
            a_req_valid = 1'b0;
            tick();
            tests++; if (a_rsp_valid !== 1'b1 || a_rsp_data !== 32'd0) begin fails++; $display("[TB] FAIL zero_read_%0d got v=%0b d=%h exp 1/00000000", zaddr[k], a_rsp_valid, a_rsp_data); end
        end
        tick();
    endtask

    task automatic test_write_read();
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 9'h1A5; a_req_din = 32'hDEADBEEF;
        #1;
        tests++; if (a_req_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 9'h1A5 || mem_din !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL wr_drive got rdy=%0b we=%0b addr=%h din=%h", a_req_ready, mem_we, mem_addr, mem_din); end
        tick();
        a_req_we = 1'b0;
        #1;
        tests++; if (a_req_ready !== 1'b1 || mem_we !== 1'b0) begin fails++; $display("[TB] FAIL rd_accept got rdy=%0b we=%0b exp 1/0", a_req_ready, mem_we); end
        tick();
        a_req_valid = 1'b0;
        tests++; if (a_rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL rd_early got v=%0b exp 0", a_rsp_valid); end
        tick();
        tests++; if (a_rsp_valid !== 1'b1 || a_rsp_data !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL raw_data got v=%0b d=%h exp 1/deadbeef", a_rsp_valid, a_rsp_data); end
        tick();
        tests++; if (a_rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL rsp_pulse got v=%0b exp 0", a_rsp_valid); end
    endtask

    task automatic test_alternate();
        int a_cnt, b_cnt, bad;
        logic exp_b;
        a_cnt = 0; b_cnt = 0; bad = 0;
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 9'd3; a_req_din = 32'h0000_0333;
        tick();
        a_req_addr = 9'd7; a_req_din = 32'h0000_0777;
        tick();
        a_req_we = 1'b0; a_req_addr = 9'd3;
        b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 9'd7;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_b = (k % 2 == 0);
            if (b_req_ready !== exp_b || a_req_ready !== !exp_b || mem_we !== 1'b0 ||
                mem_addr !== (exp_b ? 9'd7 : 9'd3)) begin
                if (bad == 0) $display("[TB] FAIL alt_grant_%0d got a=%0b b=%0b we=%0b addr=%0d exp b=%0b", k, a_req_ready, b_req_ready, mem_we, mem_addr, exp_b);
                bad++;
            end
            if (a_rsp_valid) begin a_cnt++; if (a_rsp_data !== 32'h333) bad++; end
            if (b_rsp_valid) begin b_cnt++; if (b_rsp_data !== 32'h777) bad++; end
            tick();
        end
        a_req_valid = 1'b0; b_req_valid = 1'b0;
        tests++; if (bad !== 0) begin fails++; $display("[TB] FAIL alt_pattern got %0d bad exp 0", bad); end
        tests++; if (a_cnt !== 3 || b_cnt !== 3) begin fails++; $display("[TB] FAIL alt_rsp_count got a=%0d b=%0d exp 3/3", a_cnt, b_cnt); end
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 9'h010; a_req_din = 32'hCAFE0010;
        tick();
        a_req_valid = 1'b0;
        b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 9'h010; b_rsp_ready = 1'b0;
        #1;
        tests++; if (b_req_ready !== 1'b1) begin fails++; $display("[TB] FAIL bp_first_read got %0b exp 1", b_req_ready); end
        tick();
        b_req_addr = 9'h011;
        a_req_valid = 1'b1; a_req_addr = 9'h011; a_req_din = 32'h12345678;
        #1;
        tests++; if (b_req_ready !== 1'b0 || a_req_ready !== 1'b1) begin fails++; $display("[TB] FAIL bp_back_to_back got a=%0b b=%0b exp 1/0", a_req_ready, b_req_ready); end
        tick();
        a_req_addr = 9'h012; a_req_din = 32'h0BADF00D;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (b_rsp_valid !== 1'b1 || b_rsp_data !== 32'hCAFE0010 || b_req_ready !== 1'b0) bad++;
            if (k == 0 && a_req_ready !== 1'b1) bad++;
            tick();
            a_req_valid = 1'b0;
        end
        tests++; if (bad !== 0) begin fails++; $display("[TB] FAIL bp_hold got %0d bad exp 0 (v=%0b d=%h)", bad, b_rsp_valid, b_rsp_data); end
        b_rsp_ready = 1'b1;
        #1;
        tests++; if (b_req_ready !== 1'b1 || mem_addr !== 9'h011 || mem_we !== 1'b0) begin fails++; $display("[TB] FAIL bp_release got rdy=%0b addr=%h we=%0b exp 1/011/0", b_req_ready, mem_addr, mem_we); end
        tick();
        b_req_valid = 1'b0;
        tests++; if (b_rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL bp_consumed got %0b exp 0", b_rsp_valid); end
        tick();
        tests++; if (b_rsp_valid !== 1'b1 || b_rsp_data !== 32'h12345678) begin fails++; $display("[TB] FAIL bp_next_data got v=%0b d=%h exp 1/12345678", b_rsp_valid, b_rsp_data); end
        tick();
    endtask

    task automatic test_same_cycle_writes();
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 9'h020; a_req_din = 32'h11111111;
        b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 9'h020; b_req_din = 32'h22222222;
        #1;
        tests++; if (a_req_ready !== 1'b1 || b_req_ready !== 1'b0 || mem_din !== 32'h11111111) begin fails++; $display("[TB] FAIL wr_pair_first got a=%0b b=%0b din=%h exp 1/0/11111111", a_req_ready, b_req_ready, mem_din); end
        tick();
        a_req_valid = 1'b0;
        #1;
        tests++; if (b_req_ready !== 1'b1 || mem_din !== 32'h22222222 || mem_addr !== 9'h020) begin fails++; $display("[TB] FAIL wr_pair_second got b=%0b din=%h addr=%h exp 1/22222222/020", b_req_ready, mem_din, mem_addr); end
        tick();
        b_req_valid = 1'b0;
        a_req_valid = 1'b1; a_req_we = 1'b0; a_rsp_ready = 1'b1;
        tick();
        a_req_valid = 1'b0;
        tick();
        tests++; if (a_rsp_valid !== 1'b1 || a_rsp_data !== 32'h22222222) begin fails++; $display("[TB] FAIL wr_pair_readback got v=%0b d=%h exp 1/22222222", a_rsp_valid, a_rsp_data); end
        tick();
    endtask

    task automatic test_reset_midway();
        int bad;
        bad = 0;
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 9'h020; a_rsp_ready = 1'b0;
        tick();
        a_req_valid = 1'b0;
        tick();
        tests++; if (a_rsp_valid !== 1'b1) begin fails++; $display("[TB] FAIL pending_rsp got %0b exp 1", a_rsp_valid); end
        rst_n = 1'b0;
        #1;
        tests++; if (a_rsp_valid !== 1'b0 || a_rsp_data !== 32'd0 || init_done !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 9'd0) begin fails++; $display("[TB] FAIL async_reset got v=%0b d=%h done=%0b we=%0b addr=%h", a_rsp_valid, a_rsp_data, init_done, mem_we, mem_addr); end
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        #1;
        tests++; if (mem_addr !== 9'd100) begin fails++; $display("[TB] FAIL init_cnt_100 got %0d exp 100", mem_addr); end
        rst_n = 1'b0;
        #1;
        tests++; if (mem_addr !== 9'd0 || init_done !== 1'b0) begin fails++; $display("[TB] FAIL init_restart got addr=%0d done=%0b exp 0/0", mem_addr, init_done); end
        rst_n = 1'b1;
        for (int i = 0; i < 512; i++) begin
            if (mem_addr !== 9'(i) || mem_we !== 1'b1 || init_done !== 1'b0) bad++;
            tick();
        end
        tests++; if (bad !== 0 || init_done !== 1'b1) begin fails++; $display("[TB] FAIL reinit got %0d bad done=%0b exp 0/1", bad, init_done); end
        a_req_valid = 1'b1; a_req_addr = 9'h020; a_rsp_ready = 1'b1;
        tick();
        a_req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (a_rsp_valid !== 1'b0 || mem_addr !== 9'(i)) bad++;
            tick();
        end
        tests++; if (bad !== 0) begin fails++; $display("[TB] FAIL inflight_discard got %0d bad exp 0", bad); end
    endtask

    initial begin
        rst_n = 1'b0;
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_din = '0; a_rsp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_din = '0; b_rsp_ready = 1'b0;
        test_reset();
        test_init();
        test_write_read();
        test_alternate();
        test_backpressure();
        test_same_cycle_writes();
        test_reset_midway();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram22_512x32_arb.md
# sram22_512x32_arb

Two-requester front-end for the 512x32 single-port SRAM22 macro. After reset it zero-fills the array, then shares the macro between requesters A and B with round-robin arbitration. Each port uses a valid/ready request channel and a registered valid/ready read-response channel. It sits between the macro's clk/we/wmask/addr/din/dout pins and two client blocks.

## Interface
Parameters:
- DATA_WIDTH, 32, word width; must match the macro.
- ADDR_WIDTH, 9, address width; must match the macro.
- RAM_DEPTH, 1<<ADDR_WIDTH, words cleared during init.

Ports (`p` is `a` or `b`; each port has an identical set):
- clk  in  1  clock; the macro shares this clock.
- rst_n  in  1  reset; asynchronous, active-low.
- p_req_valid  in  1  request present.
- p_req_ready  out  1  request accepted this cycle.
- p_req_we  in  1  1 = write, 0 = read.
- p_req_addr  in  ADDR_WIDTH  word address.
- p_req_din  in  DATA_WIDTH  write data.
- p_rsp_valid  out  1  read data held on p_rsp_data.
- p_rsp_ready  in  1  requester consumes the response.
- p_rsp_data  out  DATA_WIDTH  read data.
- mem_we  out  1  to macro we.
- mem_wmask  out  1  to macro wmask; constant 1.
- mem_addr  out  ADDR_WIDTH  to macro addr.
- mem_din  out  DATA_WIDTH  to macro din.
- mem_dout  in  DATA_WIDTH  from macro dout.
- init_done  out  1  high once zero-fill is complete.

## Operation
- States: INIT and RUN. Reset enters INIT, sets the init counter to 0 and points the round-robin pointer at A.
- INIT state:
  - Each cycle: mem_we=1, mem_addr=counter, mem_din=0; the counter then increments.
  - After the write to address RAM_DEPTH-1, the next state is RUN.
  - Both p_req_ready are 0 throughout INIT.
- RUN state, per-port eligibility:
  - A write is eligible whenever p_req_valid=1.
  - A read is eligible only when both hold: no read from that port was issued in the previous cycle, and the response slot is empty or is being consumed this cycle (p_rsp_ready=1).
- RUN state, arbitration and pointer:
  - If only one port is eligible, it is granted.
  - If both are eligible, the pointer's port is granted.
  - After any grant, the pointer moves to the port that was not granted.
  - With no grant, the pointer is unchanged.
- Handshake:
  - p_req_ready = RUN and the port is granted. It is combinational from p_req_valid and p_rsp_ready.
  - A requester must not make valid depend on ready.
- Memory drive:
  - mem_we, mem_addr and mem_din are combinational copies of the granted request.
  - With no grant: mem_we=0, mem_addr=0, mem_din=0. The macro performs a harmless read.
- Read return:
  - A read accepted at edge N is sampled by the macro at N.
  - The block captures mem_dout into p_rsp_data at edge N+1 and sets p_rsp_valid=1.
- Response slot:
  - p_rsp_valid and p_rsp_data hold until a cycle with p_rsp_ready=1; p_rsp_valid then clears at that edge.
  - If a capture and a consume happen at the same edge, the capture wins and p_rsp_valid stays 1.
- Writes produce no response. Read-after-write to the same address returns the new data, because the macro orders accesses in grant order.

## Timing
- Reset values:
  - p_req_ready=0, p_rsp_valid=0, p_rsp_data=0, init_done=0.
  - mem_we=1, mem_addr=0, mem_din=0. INIT begins driving immediately.
- Assertion of rst_n is asynchronous, including mid-INIT or mid-transaction. Pending responses and in-flight reads are discarded and INIT restarts from address 0.
- INIT takes exactly RAM_DEPTH cycles.
  - init_done rises at the edge after the final INIT write and stays 1 until reset.
  - The first request can be accepted in the first RUN cycle.
- Read latency: p_rsp_valid is 1 in the cycle after the cycle following acceptance, i.e. 2 edges after the request cycle.
- Per-port read throughput is one read per 2 cycles. The macro can alternate A/B reads every cycle, so combined throughput is 1 access per cycle.
- Writes are fire-and-forget at acceptance: one cycle, no latency visible to the requester.

## Test plan
- Reset, then hold both valids high during INIT:
  - p_req_ready stays 0 for 512 cycles.
  - init_done rises after cycle 512.
  - A read of addresses 0, 255 and 511 then returns 0x00000000.
- A writes 0xDEADBEEF to 0x1A5, then A reads 0x1A5 on the next cycle with a_rsp_ready=1:
  - a_rsp_valid pulses 2 edges after the read is accepted.
  - a_rsp_data=0xDEADBEEF.
- Both ports hold reads valid continuously (A addr 3, B addr 7, both rsp_ready=1):
  - Grants alternate A, B, A, B, with mem_we=0 on every granted cycle.
  - Each port gets 1 response per 2 cycles.
- B issues a read of 0x010 while holding b_rsp_ready=0:
  - b_rsp_data stays stable, and B's further reads stall (b_req_ready=0) while A's writes still proceed.
  - Raising b_rsp_ready lets B's next read be accepted that same cycle.
- Same-cycle writes from A (0x020 ← 0x11111111) and B (0x020 ← 0x22222222), pointer at A:
  - A is granted first, then B.
  - A subsequent read returns 0x22222222.
- Drop rst_n mid-INIT (counter=100) and mid-read (response in flight):
  - Outputs go to their reset values immediately, with no stale p_rsp_valid.
  - INIT restarts at address 0 and takes 512 more cycles.
